// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the HI/LO result registers.
// One operand bit is processed per cycle: shift-add for multiply, restoring
// shift-subtract for divide, followed by a single sign-fix cycle.
module md_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rdata_A,
   input  logic [WIDTH-1:0] rdata_B,
   input  logic             hilo_we,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

   state_t               state_q;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     b_q;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting into quotient}.
   logic [2*WIDTH-1:0]   acc_q;
   logic [CntW-1:0]      cnt_q;
   logic                 sgn_quo_q;
   logic                 sgn_rem_q;
   logic                 div0_q;

   logic                 op_signed;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       rem_diff;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   step_next;
   logic                 fix_signed;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   // Operand magnitudes, one iteration step, and the sign-corrected result.
   always_comb begin
      op_signed = ~op[0];
      a_mag     = (op_signed && rdata_A[WIDTH-1]) ? -rdata_A : rdata_A;
      b_mag     = (op_signed && rdata_B[WIDTH-1]) ? -rdata_B : rdata_B;

      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // The top bit of the difference is the borrow: set means "restore".
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      if (!rem_diff[WIDTH]) begin
         div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end

      step_next = op_q[1] ? div_next : mul_next;

      fix_signed = ~op_q[0];
      prod_fix   = (fix_signed && sgn_quo_q) ? -acc_q : acc_q;
      quo_fix    = (fix_signed && sgn_quo_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix    = (fix_signed && sgn_rem_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                             : acc_q[2*WIDTH-1:WIDTH];

      if (op_q[1]) begin
         // Zero divisor leaves |A| as remainder; re-signing it restores A.
         fix_hi = rem_fix;
         fix_lo = div0_q ? '1 : quo_fix;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Controller, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         op_q        <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sgn_quo_q   <= 1'b0;
         sgn_rem_q   <= 1'b0;
         div0_q      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               if (start) begin
                  op_q      <= op;
                  b_q       <= b_mag;
                  acc_q     <= {{WIDTH{1'b0}}, a_mag};
                  cnt_q     <= '0;
                  sgn_quo_q <= rdata_A[WIDTH-1] ^ rdata_B[WIDTH-1];
                  sgn_rem_q <= rdata_A[WIDTH-1];
                  div0_q    <= (rdata_B == '0);
                  busy      <= 1'b1;
                  state_q   <= StRun;
               end else if (hilo_we) begin
                  if (hilo_sel) begin
                     hi <= hilo_wdata;
                  end else begin
                     lo <= hilo_wdata;
                  end
               end
            end
            StRun: begin
               acc_q <= step_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntLast) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               hi          <= fix_hi;
               lo          <= fix_lo;
               done        <= 1'b1;
               div_by_zero <= op_q[1] & div0_q;
               busy        <= 1'b0;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/div_by_zero are queued when an
// operation is launched and compared when done pulses.
module tb_md_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rdata_A;
   logic [31:0] rdata_B;
   logic        hilo_we;
   logic        hilo_sel;
   logic [31:0] hilo_wdata;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] last_hi;
   logic [31:0] last_lo;

   md_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .rdata_A     (rdata_A),
      .rdata_B     (rdata_B),
      .hilo_we     (hilo_we),
      .hilo_sel    (hilo_sel),
      .hilo_wdata  (hilo_wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t            e;
      longint          sa;
      longint          sb;
      longint          p;
      longint          q;
      longint          r;
      longint unsigned up;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.dbz = 1'b0;
      case (o)
         2'b00: begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            up   = {32'b0, a} * {32'b0, b};
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               e.hi  = a;
               e.lo  = 32'hFFFF_FFFF;
               e.dbz = 1'b1;
            end else begin
               if (o == 2'b10) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = longint'({32'b0, a}) / longint'({32'b0, b});
                  r = longint'({32'b0, a}) % longint'({32'b0, b});
               end
               e.hi = r[31:0];
               e.lo = q[31:0];
            end
         end
      endcase
      return e;
   endfunction

   // Called at a negedge; returns at the negedge where done is seen, so a
   // following call launches back-to-back in the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
      int   n;
      bit   seen;
      exp_t e;
      sb_q.push_back(model(o, a, b));
      op      = o;
      rdata_A = a;
      rdata_B = b;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      seen  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) n++;
            if (i == 0) check("dbz_idle", {63'd0, div_by_zero}, 64'd0);
            if (inject && i == 5) begin
               start      = 1'b1;
               hilo_we    = 1'b1;
               hilo_sel   = 1'b1;
               hilo_wdata = 32'hDEAD_BEEF;
               rdata_A    = ~a;
               rdata_B    = a ^ 32'h5A5A_0001;
            end
            if (inject && i == 6) begin
               start   = 1'b0;
               hilo_we = 1'b0;
            end
            @(negedge clk);
         end
      end
      if (seen) begin
         e = sb_q.pop_front();
         check("hi", {32'd0, hi}, {32'd0, e.hi});
         check("lo", {32'd0, lo}, {32'd0, e.lo});
         check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
         check("busy_at_done", {63'd0, busy}, 64'd0);
         check("busy_cycles", 64'(n), 64'd33);
         last_hi = e.hi;
         last_lo = e.lo;
      end else begin
         check("done_seen", 64'd0, 64'd1);
         void'(sb_q.pop_front());
      end
   endtask

   // done/div_by_zero must stay low and hi/lo must hold while idle.
   task automatic idle_hold(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("done_pulse", {62'd0, done, div_by_zero}, 64'd0);
         check("hold", {hi, lo}, {last_hi, last_lo});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      op         = 2'b00;
      rdata_A    = '0;
      rdata_B    = '0;
      hilo_we    = 1'b0;
      hilo_sel   = 1'b0;
      hilo_wdata = '0;
      last_hi    = '0;
      last_lo    = '0;
      repeat (2) @(negedge clk);
      check("reset_out", {hi, lo}, 64'd0);
      check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases, the first four launched back-to-back.
      run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 1'b0);
      idle_hold(2);
      run_op(2'b11, 32'h1234, 32'd0, 1'b0);
      idle_hold(1);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
      idle_hold(1);

      // MTLO then MTHI in idle.
      hilo_we    = 1'b1;
      hilo_sel   = 1'b0;
      hilo_wdata = 32'hCAFE;
      @(negedge clk);
      hilo_we = 1'b0;
      check("mtlo", {hi, lo}, {last_hi, 32'h0000_CAFE});
      last_lo    = 32'hCAFE;
      hilo_we    = 1'b1;
      hilo_sel   = 1'b1;
      hilo_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      hilo_we = 1'b0;
      check("mthi", {hi, lo}, {32'h0BAD_F00D, 32'h0000_CAFE});
      last_hi = 32'h0BAD_F00D;
      idle_hold(2);

      // start/hilo_we/operand changes during RUN are ignored.
      run_op(2'b01, 32'h1357_9BDF, 32'h0246_8ACE, 1'b1);
      run_op(2'b10, 32'hDEAD_0000, 32'hFFFF_F123, 1'b1);
      idle_hold(1);

      // Randomised operations.
      for (int k = 0; k < 8; k++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if (k % 2 == 1) rb = -rb;
         run_op(2'(k % 4), ra, rb, 1'b0);
      end
      idle_hold(1);

      // Reset in the middle of an operation.
      op      = 2'b01;
      rdata_A = 32'hFFFF_0000;
      rdata_B = 32'h0001_0001;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy", {61'd0, busy, done, div_by_zero}, 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst     = 1'b1;
      last_hi = '0;
      last_lo = '0;
      idle_hold(2);
      run_op(2'b00, 32'd3, 32'd5, 1'b0);
      check("mult_3x5", {32'd0, lo}, 64'd15);
      idle_hold(1);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit, directly downstream of the register file.
- Consumes rdata_A/rdata_B for MULT, MULTU, DIV and DIVU, and holds the HI/LO result registers.
- The multi-cycle controller raises start, stalls on busy, and reads hi/lo for MFHI/MFLO.
- Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- ITER, 32, iteration cycles per operation. Must equal WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  launches an operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rdata_A  input  WIDTH  operand A (rs): multiplicand or dividend.
- rdata_B  input  WIDTH  operand B (rt): multiplier or divisor.
- hilo_we  input  1  MTHI/MTLO write strobe.
- hilo_sel  input  1  write target: 1 = HI, 0 = LO.
- hilo_wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; hi/lo hold the new result.
- div_by_zero  output  1  one-cycle pulse together with done for DIV/DIVU with B = 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; hi, lo, busy, done, div_by_zero, the iteration counter and all internal datapath registers clear to 0. Reset mid-operation aborts the operation; no result is written.

- States: IDLE, RUN, FIX.

- IDLE:
  - On an edge with start = 1: latch op, latch |A| and |B| (magnitude for signed ops, raw for unsigned), record sign_q = A[31]^B[31] and sign_r = A[31]; clear counter; go to RUN.
  - On an edge with start = 0 and hilo_we = 1: write hilo_wdata to HI or LO per hilo_sel.
  - start = 1 and hilo_we = 1 on the same edge: start wins, the write is dropped.

- RUN:
  - One iteration per edge; counter goes 0..ITER-1. After the edge where counter = ITER-1, go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator (unsigned magnitudes).
  - Divide: restoring shift-subtract; produces quotient and remainder magnitudes.
  - start and hilo_we are ignored.

- FIX (one edge):
  - Apply sign correction for signed ops: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write {hi, lo} = product, or hi = remainder, lo = quotient.
  - done <= 1; go to IDLE.
  - start and hilo_we are ignored in this state as well.

- Timing:
  - Call the edge that samples start E0.
  - busy is high in the cycles after E0 through E33 (33 cycles).
  - hi/lo update at E33; done is high for exactly the cycle after E33 (busy is already low then).
  - done and div_by_zero are 0 in every other cycle.
  - A new start is accepted in the done cycle (back-to-back operation).

- Divide by zero (B = 0): full latency still applies. Result lo = all ones, hi = dividend A unmodified. div_by_zero pulses with done.

- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0. This falls out naturally from the magnitude path.

- Operand timing: operands are sampled only at E0. Changes on rdata_A/rdata_B during RUN have no effect.

- Outside an operation and an MTHI/MTLO write, hi/lo hold their value indefinitely.

Test Plan:
- MULT A = 7, B = 0xFFFFFFFD (-3) -> after E33: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high 33 cycles; done high 1 cycle.
- MULTU A = B = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV A = 0xFFFFFFF9 (-7), B = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU A = 100, B = 7 -> lo = 14, hi = 2.
- DIVU A = 0x1234, B = 0 -> lo = 0xFFFFFFFF, hi = 0x1234; div_by_zero and done high together for 1 cycle.
- Control and reset cases:
  - MTLO 0xCAFE in IDLE -> lo = 0xCAFE, hi unchanged.
  - hilo_we or start pulsed during RUN -> no effect.
  - rst low at RUN cycle 10 -> busy, hi and lo go to 0 immediately; after release, a new MULT 3*5 gives lo = 15.
